// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requesting datapath and the serial subtractor.
interface serial_sub_ctrl_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (output start, a, b, bin, input busy, done, diff, bout, zero);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero);
endinterface

// File: rtl/serial_sub_ctrl_slice.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_bit_slice (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Sequences one shared full-subtractor slice over WIDTH-bit operands, LSB first.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_d_next;

  fs_bit_slice u_slice (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_d_next = {w_d, r_d[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_borrow <= bus.bin;
        r_cnt    <= '0;
      end else if (r_state == SHIFT) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_d      <= w_d_next;
        r_borrow <= w_bo;
        // Counter parks at WIDTH-1 instead of wrapping; it is cleared on the next accept.
        if (!w_last) r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_d_next;
          r_bout <= w_bo;
          r_zero <= (w_d_next == '0);
        end
      end
    end
  end

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.zero = r_zero;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] prev_diff = '0;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.bin   = tbin;
    step();
    bus.start = 1'b0;
  endtask

  // Walks the WIDTH busy cycles and stops in the done cycle; optionally pokes start mid-operation.
  task automatic finish_op(input string tag, input logic [W-1:0] ed, input logic eb,
                           input logic ez, input int poke_at);
    for (int i = 0; i < W; i++) begin
      check({tag, " busy"}, bus.busy, 1'b1);
      check({tag, " done_low"}, bus.done, 1'b0);
      check({tag, " diff_hold"}, bus.diff, prev_diff);
      bus.a   = $urandom_range(0, 255);
      bus.b   = $urandom_range(0, 255);
      bus.bin = $urandom_range(0, 1);
      if (i == poke_at) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
      end
      step();
      bus.start = 1'b0;
    end
    check({tag, " done"}, bus.done, 1'b1);
    check({tag, " busy_low"}, bus.busy, 1'b0);
    check({tag, " diff"}, bus.diff, ed);
    check({tag, " bout"}, bus.bout, eb);
    check({tag, " zero"}, bus.zero, ez);
    prev_diff = ed;
  endtask

  task automatic expect_idle(input string tag);
    step();
    check({tag, " idle_done"}, bus.done, 1'b0);
    check({tag, " idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #2;
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst diff", bus.diff, 8'h00);
    check("rst bout", bus.bout, 1'b0);
    check("rst zero", bus.zero, 1'b0);

    // rst and start together: reset dominates
    bus.start = 1'b1;
    step();
    check("rst_start busy", bus.busy, 1'b0);
    bus.start = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst busy", bus.busy, 1'b0);

    launch(8'h5A, 8'h23, 1'b0);
    finish_op("t1", 8'h37, 1'b0, 1'b0, -1);
    expect_idle("t1");

    launch(8'h10, 8'h20, 1'b0);
    finish_op("t2", 8'hF0, 1'b1, 1'b0, -1);
    expect_idle("t2");

    launch(8'h5A, 8'h23, 1'b0);
    finish_op("t4", 8'h37, 1'b0, 1'b0, 2);
    expect_idle("t4");
    step();
    check("t4 no_queue", bus.busy, 1'b0);

    launch(8'h00, 8'h00, 1'b1);
    finish_op("t3a", 8'hFF, 1'b1, 1'b0, -1);
    expect_idle("t3a");

    // abort during the fourth busy cycle
    launch(8'h33, 8'h11, 1'b0);
    step();
    step();
    step();
    check("t5 busy_before", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5 busy", bus.busy, 1'b0);
    check("t5 diff", bus.diff, 8'h00);
    check("t5 bout", bus.bout, 1'b0);
    check("t5 zero", bus.zero, 1'b0);
    prev_diff = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("t5 no_done", bus.done, 1'b0);
    end
    launch(8'h05, 8'h03, 1'b0);
    finish_op("t5b", 8'h02, 1'b0, 1'b0, -1);
    expect_idle("t5b");

    launch(8'h42, 8'h42, 1'b0);
    finish_op("t3b", 8'h00, 1'b0, 1'b1, -1);
    // back-to-back: new start accepted in the done cycle
    launch(8'h80, 8'h01, 1'b0);
    finish_op("t6", 8'h7F, 1'b0, 1'b0, -1);
    expect_idle("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
